// File: rtl/gear_box_frame_ctrl.sv
// gear_box_frame_ctrl: slot counter, round-robin source grant and bank loading for the 13-to-8 gear box
module gear_box_frame_ctrl #(
  parameter int WORD_W          = 13,
  parameter int WORDS_PER_FRAME = 8,
  parameter int SLOTS_PER_FRAME = 13
) (
  input  logic              clk_250,
  input  logic              sys_reset_n,
  input  logic              enable,
  input  logic [WORD_W-1:0] src0_data,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [WORD_W-1:0] src1_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  output logic [WORD_W-1:0] gb_data,
  output logic              gb_load,
  output logic              gb_bank,
  output logic [3:0]        gb_byte_sel,
  output logic              frame_start,
  output logic              frame_valid,
  output logic              frame_src,
  output logic [7:0]        underrun_cnt,
  input  logic              underrun_clr
);
  localparam int CW = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [3:0] LAST_SLOT = 4'(SLOTS_PER_FRAME - 1);
  localparam logic [CW-1:0] WPF = CW'(WORDS_PER_FRAME);
  logic [3:0]    r_slot;
  logic          r_gnt_vld;
  logic          r_last_grant;
  logic [CW-1:0] r_load_cnt;
  logic          w_wrap;
  logic          w_room;
  logic          w_xfer;
  logic          w_short;
  logic          w_arb_vld;
  logic          w_arb_id;
  always_comb begin
    w_wrap      = r_slot == LAST_SLOT;
    w_room      = r_gnt_vld & ~w_wrap & (r_load_cnt < WPF);
    src0_ready  = w_room & ~r_last_grant;
    src1_ready  = w_room & r_last_grant;
    w_xfer      = (src0_valid & src0_ready) | (src1_valid & src1_ready);
    w_short     = r_gnt_vld & (r_load_cnt < WPF);
    w_arb_vld   = enable & (src0_valid | src1_valid);
    w_arb_id    = (src0_valid & src1_valid) ? ~r_last_grant : src1_valid;
    gb_byte_sel = r_slot;
    frame_start = r_slot == 4'd0;
  end
  always_ff @(posedge clk_250 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_slot       <= '0;
      r_gnt_vld    <= 1'b0;
      r_last_grant <= 1'b1;
      r_load_cnt   <= '0;
      gb_data      <= '0;
      gb_load      <= 1'b0;
      gb_bank      <= 1'b0;
      frame_valid  <= 1'b0;
      frame_src    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      r_slot  <= w_wrap ? 4'd0 : r_slot + 4'd1;
      gb_load <= w_xfer;
      if (w_xfer) gb_data <= r_last_grant ? src1_data : src0_data;
      if (w_wrap) begin
        r_gnt_vld   <= w_arb_vld;
        if (w_arb_vld) r_last_grant <= w_arb_id;
        gb_bank     <= ~gb_bank;
        frame_valid <= r_gnt_vld & (r_load_cnt == WPF);
        if (r_gnt_vld) frame_src <= r_last_grant;
        r_load_cnt  <= '0;
      end else if (w_xfer) begin
        r_load_cnt <= r_load_cnt + CW'(1);
      end
      if (underrun_clr) underrun_cnt <= '0;
      else if (w_wrap & w_short & (underrun_cnt != 8'hFF)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_gear_box_frame_ctrl.sv
// tb_gear_box_frame_ctrl: directed checks of slot timing, loading, round-robin, underrun, enable and reset
module tb_gear_box_frame_ctrl;
  logic        clk_250 = 1'b0, sys_reset_n = 1'b0, enable = 1'b0, underrun_clr = 1'b0;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic [12:0] src0_data = '0, src1_data = '0, gb_data;
  logic        src0_ready, src1_ready, gb_load, gb_bank, frame_start, frame_valid, frame_src;
  logic [3:0]  gb_byte_sel;
  logic [7:0]  underrun_cnt;
  int          n_pass = 0, n_total = 0, ms = 0, mode = 0;
  logic        v0 = 1'b0, v1 = 1'b0;
  always #2 clk_250 = ~clk_250;
  gear_box_frame_ctrl dut (
    .clk_250(clk_250), .sys_reset_n(sys_reset_n), .enable(enable),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .gb_data(gb_data), .gb_load(gb_load), .gb_bank(gb_bank), .gb_byte_sel(gb_byte_sel),
    .frame_start(frame_start), .frame_valid(frame_valid), .frame_src(frame_src),
    .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic drive();
    src0_data  = 13'(ms + 1);
    src1_data  = 13'(256 + ms + 1);
    src0_valid = (mode != 0) ? 1'b0 : v0;
    src1_valid = (mode != 0) ? ((ms < 5) || (ms == 12)) : v1;
  endtask
  task automatic tick();
    @(posedge clk_250);
    #1;
    ms = (ms == 12) ? 0 : ms + 1;
    drive();
  endtask
  task automatic go_to(input int s);
    for (int i = 0; i < 13 && ms != s; i++) tick();
  endtask
  task automatic next_frame();
    tick();
    go_to(0);
  endtask
  initial begin
    repeat (3) @(posedge clk_250);
    #1;
    chk("rst_sel", gb_byte_sel, 0);
    chk("rst_start", frame_start, 1);
    chk("rst_bank", gb_bank, 0);
    chk("rst_load", gb_load, 0);
    chk("rst_data", gb_data, 0);
    chk("rst_rdy0", src0_ready, 0);
    chk("rst_rdy1", src1_ready, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_src", frame_src, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    enable = 1'b1;
    v0 = 1'b1;
    ms = 0;
    drive();
    sys_reset_n = 1'b1;
    go_to(3);
    chk("idle_rdy0", src0_ready, 0);
    chk("idle_sel", gb_byte_sel, 3);
    go_to(12);
    chk("wrap_rdy0", src0_ready, 0);
    chk("wrap_start", frame_start, 0);
    tick();
    chk("f1_bank", gb_bank, 1);
    chk("f1_start", frame_start, 1);
    chk("f1_rdy0", src0_ready, 1);
    chk("f1_rdy1", src1_ready, 0);
    chk("f1_load0", gb_load, 0);
    for (int s = 1; s <= 8; s++) begin
      tick();
      chk("f1_load", gb_load, 1);
      chk("f1_data", gb_data, s);
    end
    tick();
    chk("f1_load9", gb_load, 0);
    chk("f1_full_rdy0", src0_ready, 0);
    next_frame();
    chk("f2_fv", frame_valid, 1);
    chk("f2_src", frame_src, 0);
    chk("f2_bank", gb_bank, 0);
    chk("f2_ucnt", underrun_cnt, 0);
    go_to(5);
    sys_reset_n = 1'b0;
    #1;
    chk("mrst_sel", gb_byte_sel, 0);
    chk("mrst_start", frame_start, 1);
    chk("mrst_bank", gb_bank, 0);
    chk("mrst_rdy0", src0_ready, 0);
    chk("mrst_fv", frame_valid, 0);
    chk("mrst_load", gb_load, 0);
    chk("mrst_data", gb_data, 0);
    @(posedge clk_250);
    #1;
    sys_reset_n = 1'b1;
    ms = 0;
    drive();
    go_to(6);
    chk("r0_fv", frame_valid, 0);
    next_frame();
    chk("r1_fv", frame_valid, 0);
    chk("r1_rdy0", src0_ready, 1);
    v1 = 1'b1;
    drive();
    for (int i = 0; i < 4; i++) begin
      next_frame();
      chk("rr_fv", frame_valid, 1);
      chk("rr_src", frame_src, 32'(i % 2));
      if (i == 0) begin
        chk("rr_rdy1", src1_ready, 1);
        tick();
        chk("rr_data1", gb_data, 13'h101);
      end
    end
    go_to(11);
    mode = 1;
    go_to(12);
    chk("ur_pre_ucnt", underrun_cnt, 0);
    next_frame();
    chk("ur_f_fv", frame_valid, 1);
    chk("ur_f_src", frame_src, 0);
    chk("ur_f_rdy1", src1_ready, 1);
    go_to(6);
    chk("ur_stall_load", gb_load, 0);
    chk("ur_stall_rdy1", src1_ready, 1);
    go_to(12);
    chk("ur_wrap_rdy1", src1_ready, 0);
    chk("ur_wrap_rdy0", src0_ready, 0);
    tick();
    chk("ur_ucnt1", underrun_cnt, 1);
    chk("ur_fv", frame_valid, 0);
    chk("ur_src", frame_src, 1);
    repeat (253) next_frame();
    chk("ur_ucnt254", underrun_cnt, 254);
    next_frame();
    chk("ur_ucnt255", underrun_cnt, 255);
    repeat (45) next_frame();
    chk("ur_sat", underrun_cnt, 255);
    go_to(3);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_mid", underrun_cnt, 0);
    next_frame();
    chk("clr_then_inc", underrun_cnt, 1);
    go_to(12);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_priority", underrun_cnt, 0);
    go_to(12);
    mode = 0;
    v0 = 1'b1;
    v1 = 1'b1;
    enable = 1'b0;
    drive();
    tick();
    chk("en_close_ucnt", underrun_cnt, 1);
    chk("en_close_fv", frame_valid, 0);
    enable = 1'b1;
    for (int s = 0; s < 13; s++) begin
      chk("en_off_rdy0", src0_ready, 0);
      chk("en_off_rdy1", src1_ready, 0);
      tick();
    end
    chk("en_idle_fv", frame_valid, 0);
    chk("en_idle_ucnt", underrun_cnt, 1);
    next_frame();
    chk("en_back_fv", frame_valid, 1);
    chk("en_back_src", frame_src, 0);
    chk("en_back_ucnt", underrun_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/gear_box_frame_ctrl.md
# gear_box_frame_ctrl

Frame scheduler and source arbiter in front of the double-banked 13-to-8 gear box. Runs a free-running slot counter that defines the gear-box output frame, grants one of two ADC word sources per frame (round-robin), loads exactly WORDS_PER_FRAME words into the load bank, swaps banks at frame wrap, and flags frames that did not fill. All logic is on one clock.

## Interface
- WORD_W, default 13: ADC word width.
- WORDS_PER_FRAME, default 8: words loaded per frame. Must be ≤ SLOTS_PER_FRAME-1.
- SLOTS_PER_FRAME, default 13: output byte slots per frame. Legal range 2..16.
- clk_250  in  1  sole clock.
- sys_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new grants; sampled only at the arbitration slot.
- src0_data  in  WORD_W  source 0 word.
- src0_valid  in  1  source 0 word available.
- src0_ready  out  1  source 0 word accepted this cycle when valid is also high.
- src1_data / src1_valid / src1_ready: same as source 0, for source 1.
- gb_data  out  WORD_W  word written into the gear-box load bank.
- gb_load  out  1  one-cycle write strobe for gb_data.
- gb_bank  out  1  bank being loaded; the output bank is ~gb_bank.
- gb_byte_sel  out  4  current slot; this is the gear-box byte select.
- frame_start  out  1  high while the slot counter is 0.
- frame_valid  out  1  the frame now being output was completely loaded.
- frame_src  out  1  source id of the frame now being output.
- underrun_cnt  out  8  saturating count of short frames.
- underrun_clr  in  1  synchronous clear of underrun_cnt.

## Operation
- Slot counter counts 0..SLOTS_PER_FRAME-1 and wraps to 0. It runs continuously out of reset. Wrap is the cycle where slot = SLOTS_PER_FRAME-1.
- **Arbitration** happens in the wrap cycle. If enable=1:
  - both sources valid: grant the source that is not last_grant;
  - one source valid: grant that source;
  - no source valid: no grant.
- Grant, and last_grant when a grant is made, register at the wrap edge. The grant holds for the whole frame.
- **Loading window** is slots 0..SLOTS_PER_FRAME-2.
  - srcN_ready = granted(N) & in-window & (load_cnt < WORDS_PER_FRAME). It is driven combinationally from registers only.
  - A transfer occurs when valid & ready. load_cnt increments on each transfer.
  - A valid that drops mid-frame simply stalls loading. No reordering.
- Ready is never asserted in the wrap slot, and never for an ungranted source.
- **Frame close**, at the wrap edge:
  - gb_bank toggles.
  - frame_valid ← granted & (load_cnt = WORDS_PER_FRAME).
  - frame_src ← grant id, or holds its value if there was no grant.
  - load_cnt ← 0.
- **Underrun** means granted & load_cnt < WORDS_PER_FRAME at frame close. underrun_cnt increments and saturates at 255. A frame with no grant is idle and is not an underrun.
- underrun_clr has priority over a simultaneous increment; the result is 0.
- **Reset values:** slot 0, gb_bank 0, gb_load 0, gb_data 0, no grant, last_grant 1 (so source 0 wins the first tie), load_cnt 0, frame_valid 0, frame_src 0, underrun_cnt 0, both ready 0, frame_start 1.
- Reset asserted mid-frame aborts loading immediately. The partial bank contents are don't-care, and frame_valid stays 0.

## Timing
- The first arbitration is at the first wrap after reset, so frame 0 after reset is always idle.
- A transfer accepted in slot s gives gb_load=1 and gb_data=word in slot s+1. That is at most slot SLOTS_PER_FRAME-1, so gb_bank is unchanged across the write.
- With continuous valid, transfers occur in slots 0..WORDS_PER_FRAME-1 and gb_load in slots 1..WORDS_PER_FRAME.
- frame_valid and frame_src change only at the wrap edge. They are stable for the full output frame.
- gb_byte_sel equals the slot with zero latency.
- frame_start is combinational from the slot register.

## Test plan
- **Reset mid-frame:** drop sys_reset_n at slot 5 while source 0 is loading -> all outputs go to reset values asynchronously. After release, the first frame has frame_valid=0.
- **Single source:** src0 continuously valid with data 1..8 -> frame 0 idle. Frame 1: gb_bank=1, gb_load in slots 1..8 with gb_data 1..8. At the next wrap: frame_valid=1, frame_src=0, gb_bank=0, underrun_cnt=0.
- **Round-robin:** both sources valid continuously -> frame_src sequence 0,1,0,1… and each frame_valid=1.
- **Underrun:** source 1 alone supplies 5 words then drops valid -> no ready in the wrap slot. At close, underrun_cnt=1 and the next frame_valid=0. Repeating for 300 frames saturates underrun_cnt at 255.
- **Enable:** enable=0 in the wrap slot with both sources valid -> no ready asserted for the whole next frame. The following frame_valid=0 and underrun_cnt is unchanged.
- **Clear priority:** underrun_clr pulsed in the same wrap cycle as an underrun -> underrun_cnt=0.
